// File: rtl/counter_monitor_if.sv
// Observation bus of an up/down counter: sample enable, value and its complement.
interface counter_monitor_if #(
    parameter int N = 8
);
    logic         en;
    logic [N-1:0] value;
    logic [N-1:0] value_inv;

    modport master (output en, value, value_inv);
    modport slave  (input  en, value, value_inv);
endinterface

// File: rtl/counter_monitor.sv
// Purpose: recovers step direction, loads and bus integrity from a counter's value/value_inv bus.
// Latency: one cycle from sample to registered flag; stats gated by `COUNTER_MONITOR_STATS_EN.
// Backpressure: none; pure observer, en=0 freezes state and drops pulses.
module counter_monitor #(
    parameter int N = 8
`ifdef COUNTER_MONITOR_STATS_EN
    , parameter int STAT_W = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    counter_monitor_if.slave        bus,
    input  logic                    clr,
    output logic                    dir,
    output logic                    dir_valid,
    output logic                    dir_change,
    output logic                    load_det,
    output logic [N-1:0]            load_value,
    output logic                    err_inv,
    output logic                    err_sticky
`ifdef COUNTER_MONITOR_STATS_EN
    , output logic [STAT_W-1:0]     up_count
    , output logic [STAT_W-1:0]     down_count
    , output logic [STAT_W-1:0]     load_count
`endif
);

    typedef enum logic {INIT, TRACK} state_t;

    localparam logic [N-1:0] STEP_UP = 1;

    state_t       state_q, state_d;
    logic [N-1:0] prev_q, prev_d;
    logic [N-1:0] delta;
    logic         sample_ok;
    logic         classify;
    logic         dir_d, dir_valid_d, dir_change_d, load_det_d, err_inv_d, err_sticky_d;
    logic [N-1:0] load_value_d;

    assign sample_ok = (bus.value_inv == ~bus.value);
    assign delta     = bus.value - prev_q;
    assign classify  = bus.en && sample_ok && (state_q == TRACK);

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        dir_d        = dir;
        dir_valid_d  = dir_valid;
        dir_change_d = 1'b0;
        load_det_d   = 1'b0;
        load_value_d = load_value;
        err_inv_d    = 1'b0;
        if (bus.en) begin
            if (!sample_ok) begin
                // Corrupt samples are dropped entirely; prev keeps the last good value.
                err_inv_d = 1'b1;
            end else if (state_q == INIT) begin
                state_d = TRACK;
                prev_d  = bus.value;
            end else begin
                prev_d = bus.value;
                if (delta == STEP_UP) begin
                    dir_d        = 1'b1;
                    dir_valid_d  = 1'b1;
                    dir_change_d = dir_valid && !dir;
                end else if (delta == '1) begin
                    dir_d        = 1'b0;
                    dir_valid_d  = 1'b1;
                    dir_change_d = dir_valid && dir;
                end else begin
                    load_det_d   = 1'b1;
                    load_value_d = bus.value;
                end
            end
        end
        // A mismatch in the same cycle as clr still leaves the sticky bit set.
        err_sticky_d = err_inv_d || (err_sticky && !clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            prev_q     <= '0;
            dir        <= 1'b0;
            dir_valid  <= 1'b0;
            dir_change <= 1'b0;
            load_det   <= 1'b0;
            load_value <= '0;
            err_inv    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            dir        <= dir_d;
            dir_valid  <= dir_valid_d;
            dir_change <= dir_change_d;
            load_det   <= load_det_d;
            load_value <= load_value_d;
            err_inv    <= err_inv_d;
            err_sticky <= err_sticky_d;
        end
    end

`ifdef COUNTER_MONITOR_STATS_EN
    logic is_up, is_down, is_load;

    assign is_up   = classify && (delta == STEP_UP);
    assign is_down = classify && (delta == '1);
    assign is_load = classify && !is_up && !is_down;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_count   <= '0;
            down_count <= '0;
            load_count <= '0;
        end else if (clr) begin
            up_count   <= '0;
            down_count <= '0;
            load_count <= '0;
        end else begin
            if (is_up && up_count != '1)
                up_count <= up_count + STAT_W'(1);
            if (is_down && down_count != '1)
                down_count <= down_count + STAT_W'(1);
            if (is_load && load_count != '1)
                load_count <= load_count + STAT_W'(1);
        end
    end
`else
    logic unused_classify;
    assign unused_classify = classify;
`endif

endmodule

// File: tb/tb_counter_monitor.sv
// Scoreboard bench for counter_monitor: directed samples push expectations, a negedge monitor checks them.
module tb_counter_monitor;

    localparam int K_NONE = 0;
    localparam int K_UP   = 1;
    localparam int K_DN   = 2;
    localparam int K_LD   = 3;
    localparam int SMAX   = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       dir, dir_valid, dir_change, load_det, err_inv, err_sticky;
    logic [7:0] load_value;

    typedef struct {
        logic       dir, dv, dc, ld, ei, es;
        logic [7:0] lv;
        int         upc, dnc, ldc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   failed = 0;
    int   up_m = 0, dn_m = 0, ld_m = 0;

    counter_monitor_if #(.N(8)) bus ();

    always #5 clk = ~clk;

`ifdef COUNTER_MONITOR_STATS_EN
    logic [3:0] up_count, down_count, load_count;
    counter_monitor #(.N(8), .STAT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .clr(clr),
        .dir(dir), .dir_valid(dir_valid), .dir_change(dir_change),
        .load_det(load_det), .load_value(load_value),
        .err_inv(err_inv), .err_sticky(err_sticky),
        .up_count(up_count), .down_count(down_count), .load_count(load_count)
    );
`else
    counter_monitor #(.N(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .clr(clr),
        .dir(dir), .dir_valid(dir_valid), .dir_change(dir_change),
        .load_det(load_det), .load_value(load_value),
        .err_inv(err_inv), .err_sticky(err_sticky)
    );
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] xp);
        tests++;
        if (act !== xp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, xp, $time);
        end
    endtask

    // Monitor: one expectation per driven cycle, checked half a cycle after the edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            chk("dir",        32'(dir),        32'(x.dir));
            chk("dir_valid",  32'(dir_valid),  32'(x.dv));
            chk("dir_change", 32'(dir_change), 32'(x.dc));
            chk("load_det",   32'(load_det),   32'(x.ld));
            chk("load_value", 32'(load_value), 32'(x.lv));
            chk("err_inv",    32'(err_inv),    32'(x.ei));
            chk("err_sticky", 32'(err_sticky), 32'(x.es));
`ifdef COUNTER_MONITOR_STATS_EN
            chk("up_count",   32'(up_count),   32'(x.upc));
            chk("down_count", 32'(down_count), 32'(x.dnc));
            chk("load_count", 32'(load_count), 32'(x.ldc));
`endif
        end
    end

    task automatic s(input bit e, input logic [7:0] v, input bit bad, input bit c, input int kind,
                     input bit x_dir, input bit x_dv, input bit x_dc, input logic [7:0] x_lv,
                     input bit x_es);
        exp_t x;
        @(negedge clk); #1;
        bus.en        = e;
        bus.value     = v;
        bus.value_inv = bad ? v : ~v;
        clr           = c;
        if (!rst_n || c) begin
            up_m = 0; dn_m = 0; ld_m = 0;
        end else begin
            if (kind == K_UP && up_m < SMAX) up_m++;
            if (kind == K_DN && dn_m < SMAX) dn_m++;
            if (kind == K_LD && ld_m < SMAX) ld_m++;
        end
        x.dir = x_dir; x.dv = x_dv; x.dc = x_dc; x.lv = x_lv; x.es = x_es;
        x.ld  = (kind == K_LD);
        x.ei  = e && bad && rst_n;
        x.upc = up_m; x.dnc = dn_m; x.ldc = ld_m;
        @(posedge clk);
        exp_q.push_back(x);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk); #1;
        rst_n  = 1'b0;
        bus.en = 1'b0;
        clr    = 1'b0;
        up_m = 0; dn_m = 0; ld_m = 0;
        for (int i = 0; i < n; i++) s(1, 8'h55, 0, 0, K_NONE, 0, 0, 0, 8'h00, 0);
        @(negedge clk); #1;
        rst_n  = 1'b1;
        bus.en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en = 1'b0; bus.value = 8'h00; bus.value_inv = 8'hFF;

        // Up run
        do_reset(2);
        s(1, 8'h10, 0, 0, K_NONE, 0, 0, 0, 8'h00, 0);
        s(1, 8'h11, 0, 0, K_UP,   1, 1, 0, 8'h00, 0);
        s(1, 8'h12, 0, 0, K_UP,   1, 1, 0, 8'h00, 0);
        s(1, 8'h13, 0, 0, K_UP,   1, 1, 0, 8'h00, 0);

        // Wrap-around in both directions
        do_reset(1);
        s(1, 8'hFE, 0, 0, K_NONE, 0, 0, 0, 8'h00, 0);
        s(1, 8'hFF, 0, 0, K_UP,   1, 1, 0, 8'h00, 0);
        s(1, 8'h00, 0, 0, K_UP,   1, 1, 0, 8'h00, 0);
        s(1, 8'hFF, 0, 0, K_DN,   0, 1, 1, 8'h00, 0);
        s(1, 8'h00, 0, 0, K_UP,   1, 1, 1, 8'h00, 0);
        s(1, 8'hFF, 0, 0, K_DN,   0, 1, 1, 8'h00, 0);
        s(1, 8'hFE, 0, 0, K_DN,   0, 1, 0, 8'h00, 0);

        // Loads, repeated value, back-to-back loads, enable gap
        do_reset(1);
        s(1, 8'h05, 0, 0, K_NONE, 0, 0, 0, 8'h00, 0);
        s(1, 8'h06, 0, 0, K_UP,   1, 1, 0, 8'h00, 0);
        s(1, 8'h80, 0, 0, K_LD,   1, 1, 0, 8'h80, 0);
        s(1, 8'h81, 0, 0, K_UP,   1, 1, 0, 8'h80, 0);
        s(1, 8'h81, 0, 0, K_LD,   1, 1, 0, 8'h81, 0);
        s(1, 8'h10, 0, 0, K_LD,   1, 1, 0, 8'h10, 0);
        s(0, 8'h11, 0, 0, K_NONE, 1, 1, 0, 8'h10, 0);
        s(1, 8'h12, 0, 0, K_LD,   1, 1, 0, 8'h12, 0);

        // Integrity: bad sample in INIT, clr racing a mismatch, classification across a bad sample
        do_reset(1);
        s(1, 8'h20, 1, 0, K_NONE, 0, 0, 0, 8'h00, 1);
        s(1, 8'h20, 0, 0, K_NONE, 0, 0, 0, 8'h00, 1);
        s(1, 8'h21, 1, 1, K_NONE, 0, 0, 0, 8'h00, 1);
        s(1, 8'h21, 0, 0, K_UP,   1, 1, 0, 8'h00, 1);
        s(1, 8'h22, 0, 1, K_UP,   1, 1, 0, 8'h00, 0);
        s(1, 8'h24, 0, 0, K_LD,   1, 1, 0, 8'h24, 0);

        // Reset mid-stream, then recapture without a load
        do_reset(1);
        s(1, 8'h3F, 0, 0, K_NONE, 0, 0, 0, 8'h00, 0);
        s(1, 8'h40, 0, 0, K_UP,   1, 1, 0, 8'h00, 0);
        do_reset(2);
        s(1, 8'h90, 0, 0, K_NONE, 0, 0, 0, 8'h00, 0);
        s(1, 8'h91, 0, 0, K_UP,   1, 1, 0, 8'h00, 0);

        // Long up run: statistics saturate, then clr wins over the same-cycle step
        do_reset(1);
        s(1, 8'h00, 0, 0, K_NONE, 0, 0, 0, 8'h00, 0);
        for (int i = 1; i <= 20; i++) s(1, 8'(i), 0, 0, K_UP, 1, 1, 0, 8'h00, 0);
        s(1, 8'd21, 0, 1, K_UP, 1, 1, 0, 8'h00, 0);
        s(1, 8'd22, 0, 0, K_UP, 1, 1, 0, 8'h00, 0);

        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/counter_monitor.md
# counter_monitor

Receive-side checker for the up/down counter's output bus. It samples `value` and `value_inv` every clock and recovers the control the counter was driven with: step direction, load events and the loaded value. It also checks the complementary-bus integrity and, optionally, keeps event statistics. It sits on the observation side of any counter instance, next to the debug/status register block.

## Interface
- `N`, 8: counter width; legal range 2..16.
- `STAT_W`, 16: width of each statistics counter (only used with `COUNTER_MONITOR_STATS_EN`).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  sample enable; when 0, no sampling, state and outputs hold, pulses deassert.
- `clr`  in  1  synchronous clear of sticky error and statistics; has priority over counting in the same cycle.
- `value`  in  N  counter value under observation.
- `value_inv`  in  N  complement bus; must equal `~value`.
- `dir`  out  1  last recovered direction: 1 = up, 0 = down.
- `dir_valid`  out  1  high once at least one ±1 step has been classified.
- `dir_change`  out  1  one-cycle pulse: a step whose direction differs from the previous `dir`, with `dir_valid` already 1.
- `load_det`  out  1  one-cycle pulse: a load was detected.
- `load_value`  out  N  value captured at the last `load_det`.
- `err_inv`  out  1  one-cycle pulse: integrity mismatch on this sample.
- `err_sticky`  out  1  set by `err_inv`, cleared by `clr` or reset.
- `up_count`, `down_count`, `load_count`  out  STAT_W each  statistics; present only with the macro.

## Operation
- FSM states:
  - INIT: no valid previous sample yet. Entered on reset.
  - TRACK: a previous sample `prev` is held.
- INIT -> TRACK: first enabled sample with a good integrity check. `prev` <= `value`; no classification and no pulses for this sample.
- In TRACK, each enabled, integrity-good sample is classified with delta = `value - prev` mod 2^N:
  - delta = 1: up step. `dir` <= 1, `dir_valid` <= 1.
  - delta = 2^N-1: down step. `dir` <= 0, `dir_valid` <= 1.
  - Any other delta, including 0: load. `load_det` pulses and `load_value` <= `value`. `dir` and `dir_valid` are unchanged.
  - In all three cases, `prev` <= `value`.
- Wrap-around is a step, not a load: 0xFF -> 0x00 is up and 0x00 -> 0xFF is down (N=8).
- Known ambiguity, accepted: a load whose `start_value` equals `prev±1` is classified as a step.
- `dir_change` pulses only on a step that flips `dir` while `dir_valid` was already 1. The first step never pulses.
- Integrity failure (`value_inv != ~value`), in either state:
  - `err_inv` pulses and `err_sticky` sets.
  - The sample is discarded: `prev`, the state, `dir` and `load_value` are unchanged, and no step/load pulse is issued.
  - The next good sample is classified against the last good `prev`.
- `clr` clears `err_sticky` and the statistics only. If `err_inv` fires in the same cycle as `clr`, `err_sticky` ends at 1 (set wins over clear).

## Timing
- All outputs are registered. A sample presented before edge k produces its pulses/updates visible right after edge k, i.e. one cycle of latency from bus change to flag.
- Pulses are exactly one cycle wide. Back-to-back events give back-to-back pulses.
- Reset values: state INIT, `prev` 0, `dir` 0, `dir_valid` 0, `dir_change` 0, `load_det` 0, `load_value` 0, `err_inv` 0, `err_sticky` 0, all stats 0.
- Reset asserted mid-stream forces INIT immediately. The first sample after release is only captured, never classified as a load.
- `en` low for any number of cycles: the next enabled sample is compared against the last sampled `prev`. Gaps longer than one count therefore report a load; this is intended.

## Configuration
- `COUNTER_MONITOR_STATS_EN` defined:
  - `up_count`, `down_count` and `load_count` exist.
  - Each increments by 1 on its classified event and saturates at 2^STAT_W-1.
  - All three are cleared by `clr` and by reset.
- Not defined: the three ports and their registers are absent. All other behaviour is identical.

## Test plan
- Up run: reset, then `value` 0x10, 0x11, 0x12, 0x13 with good complement -> first sample silent; then three up steps, `dir`=1, `dir_valid`=1, no `dir_change`; `up_count`=3 with the macro.
- Wrap: 0xFE, 0xFF, 0x00, 0xFF, 0x00 -> up, up, down (`dir_change` pulse), up (`dir_change` pulse); no `load_det`.
- Load: 0x05, 0x06, 0x80, 0x81 -> step, `load_det` pulse with `load_value`=0x80, then step; a repeat 0x81, 0x81 -> `load_det` with `load_value`=0x81.
- Integrity: 0x20, then `value`=0x21 with `value_inv`=0x00, then 0x21 good -> `err_inv` pulse, `err_sticky`=1, and 0x21 is classified as an up step from 0x20; `clr` -> `err_sticky`=0. `clr` in the same cycle as a new mismatch -> `err_sticky` stays 1.
- Reset mid-stream: at 0x40, assert `rst_n`=0 for 2 cycles, release, then feed 0x90, 0x91 -> all outputs at reset values during reset; 0x90 silent, 0x91 up step, no `load_det`.
- Saturation (macro on, STAT_W=4): 20 consecutive up steps -> `up_count`=15, holds; `clr` -> 0.
